// File: rtl/lsu_pkg.sv
// Shared definitions for load_store_unit: state encoding, default memory size
// and the address range check.
package lsu_pkg;

  localparam int unsigned LSU_MEM_BYTES = 128;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_RD   = 2'd1;
  localparam lsu_state_t S_WR   = 2'd2;
  localparam lsu_state_t S_RESP = 2'd3;

  // A word needs two in-range bytes; a byte needs one.
  function automatic logic lsu_in_range(input logic [15:0] addr, input logic is_byte,
                                        input int unsigned mem_bytes);
    logic [31:0] a32;
    a32 = {16'd0, addr};
    return is_byte ? (a32 <= mem_bytes - 32'd1) : (a32 <= mem_bytes - 32'd2);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte extract/extend and byte merge for a big-endian 16-bit word.
// i_hi selects the high byte [15:8] as the target lane, otherwise the low byte.
module lsu_byte_lane (
  input  logic [15:0] i_word,
  input  logic        i_hi,
  input  logic        i_signed,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_ext,
  output logic [15:0] o_merged
);

  logic [7:0] w_sel;

  always_comb begin
    w_sel    = i_hi ? i_word[15:8] : i_word[7:0];
    o_ext    = {{8{i_signed & w_sel[7]}}, w_sel};
    o_merged = i_hi ? {i_byte, i_word[7:0]} : {i_word[15:8], i_byte};
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready front end to a big-endian 16-bit byte-addressed memory.
// Byte loads and read-modify-write byte stores are built only when LSU_BYTE_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [15:0] RespRData,
  output logic        RespError,
  output logic [15:0] MemAddress,
  output logic [15:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [15:0] MemReadData
);

  lsu_state_t  r_state;
  logic        r_write;
  logic        r_err;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;

  logic        w_legal;
  logic [15:0] w_base;
  logic [15:0] w_rd_data;
  lsu_state_t  w_accept_state;

`ifdef LSU_BYTE_EN
  logic        r_byte;
  logic        r_signed;
  logic        r_hi;
  logic        w_hi;
  logic [15:0] w_ext;
  logic [15:0] w_merged;

  // The last byte has no successor, so it is reached as the low lane of the word below it.
  always_comb begin
    w_legal = lsu_in_range(ReqAddr, ReqByte, MEM_BYTES);
    w_hi    = ({16'd0, ReqAddr} <= MEM_BYTES - 32'd2);
    w_base  = (ReqByte && !w_hi) ? ReqAddr - 16'd1 : ReqAddr;
  end

  lsu_byte_lane u_byte_lane (
    .i_word   (MemReadData),
    .i_hi     (r_hi),
    .i_signed (r_signed),
    .i_byte   (r_wdata[7:0]),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  assign w_rd_data = r_byte ? w_ext : MemReadData;
`else
  logic w_unused;

  assign w_unused  = ReqSigned;
  assign w_legal   = !ReqByte && lsu_in_range(ReqAddr, 1'b0, MEM_BYTES);
  assign w_base    = ReqAddr;
  assign w_rd_data = MemReadData;
`endif

  always_comb begin
    w_accept_state = S_RESP;
    if (w_legal) begin
      if (!ReqWrite) w_accept_state = S_RD;
`ifdef LSU_BYTE_EN
      else if (ReqByte) w_accept_state = S_RD;
`endif
      else w_accept_state = S_WR;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef LSU_BYTE_EN
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_hi     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (ReqValid) begin
          r_write <= ReqWrite;
          r_err   <= !w_legal;
          r_addr  <= w_base;
          r_wdata <= ReqWData;
          r_rdata <= '0;
          r_state <= w_accept_state;
`ifdef LSU_BYTE_EN
          r_byte   <= ReqByte;
          r_signed <= ReqSigned;
          r_hi     <= w_hi;
`endif
        end
        S_RD: begin
`ifdef LSU_BYTE_EN
          if (r_write) begin
            r_wdata <= w_merged;
            r_state <= S_WR;
          end else begin
            r_rdata <= w_rd_data;
            r_state <= S_RESP;
          end
`else
          r_rdata <= w_rd_data;
          r_state <= S_RESP;
`endif
        end
        S_WR:    r_state <= S_RESP;
        S_RESP:  if (RespReady) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ReqReady     = (r_state == S_IDLE) && !Reset;
    RespValid    = (r_state == S_RESP);
    RespRData    = RespValid ? r_rdata : '0;
    RespError    = RespValid & r_err;
    MemRead      = (r_state == S_RD);
    MemWrite     = (r_state == S_WR) && !Reset;
    MemAddress   = ((r_state == S_RD) || (r_state == S_WR)) ? r_addr : '0;
    MemWriteData = (r_state == S_WR) ? r_wdata : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

`ifdef LSU_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  localparam int unsigned MB = 128;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic        ReqByte = 1'b0;
  logic        ReqSigned = 1'b0;
  logic [15:0] ReqAddr = '0;
  logic [15:0] ReqWData = '0;
  logic        RespValid;
  logic        RespReady = 1'b1;
  logic [15:0] RespRData;
  logic        RespError;
  logic [15:0] MemAddress;
  logic [15:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] MemReadData;

  logic [7:0] mem     [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
    .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData), .RespError(RespError),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemReadData(MemReadData)
  );

  // Big-endian memory: byte[a] is the high byte of the word read at a.
  always_comb begin
    MemReadData = 16'h0000;
    if (MemAddress < 16'd127)
      MemReadData = {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]};
  end

  always @(posedge Clock) begin
    if (MemWrite === 1'b1 && MemAddress < 16'd127) begin
      mem[MemAddress[6:0]]        <= MemWriteData[15:8];
      mem[MemAddress[6:0] + 7'd1] <= MemWriteData[7:0];
    end
  end

  // Reference: memory as a byte array, results from the access rules directly.
  task automatic ref_exec(input bit wr, input bit by, input bit sg, input logic [15:0] a,
                          input logic [15:0] wd, output logic [15:0] er, output logic ee,
                          output int el, output int enr, output int enw, output logic [15:0] ema);
    bit legal;
    logic [7:0] b;
    legal = by ? (BYTE_EN && a <= 16'd127) : (a <= 16'd126);
    er = '0; ee = 1'b0; el = 1; enr = 0; enw = 0; ema = '0;
    if (!legal) begin
      ee = 1'b1;
    end else if (!by) begin
      ema = a; el = 2;
      if (!wr) begin
        er = {ref_mem[a], ref_mem[a + 16'd1]}; enr = 1;
      end else begin
        ref_mem[a] = wd[15:8]; ref_mem[a + 16'd1] = wd[7:0]; enw = 1;
      end
    end else begin
      ema = (a == 16'd127) ? 16'd126 : a;
      if (!wr) begin
        b = ref_mem[a];
        er = sg ? {{8{b[7]}}, b} : {8'h00, b};
        el = 2; enr = 1;
      end else begin
        ref_mem[a] = wd[7:0];
        el = 3; enr = 1; enw = 1;
      end
    end
  endtask

  task automatic do_req(input bit wr, input bit by, input bit sg, input logic [15:0] a,
                        input logic [15:0] wd, input int hold,
                        output logic [15:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output logic [15:0] ma,
                        output bit stable, output bit idle_ok, output bit tmo);
    int w;
    nrd = 0; nwr = 0; ma = '0; stable = 1'b1; idle_ok = 1'b0; tmo = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    ReqWrite = wr; ReqByte = by; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    ReqValid = 1'b1; RespReady = (hold == 0);
    w = 0;
    while (ReqReady !== 1'b1 && w < 20) begin @(posedge Clock); #1; w++; end
    if (w >= 20) begin tmo = 1'b1; ReqValid = 1'b0; RespReady = 1'b1; return; end
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (RespValid !== 1'b1 && lat < 20) begin
      if (MemRead === 1'b1) nrd++;
      if (MemWrite === 1'b1) nwr++;
      if (MemRead === 1'b1 || MemWrite === 1'b1) ma = MemAddress;
      @(posedge Clock); #1;
      lat++;
    end
    if (RespValid !== 1'b1) begin tmo = 1'b1; RespReady = 1'b1; return; end
    rd = RespRData; er = RespError;
    if (ReqReady !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0) stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock); #1;
      if (RespValid !== 1'b1 || RespRData !== rd || RespError !== er || ReqReady !== 1'b0 ||
          MemRead !== 1'b0 || MemWrite !== 1'b0) stable = 1'b0;
    end
    RespReady = 1'b1;
    @(posedge Clock); #1;
    idle_ok = (ReqReady === 1'b1 && RespValid === 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (ReqReady !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0", ReqReady);
    end
    checks++;
    if ({RespValid, RespError, MemWrite, MemRead} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {RespValid, RespError, MemWrite, MemRead});
    end
    checks++;
    if ({RespRData, MemAddress, MemWriteData} !== 48'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {RespRData, MemAddress, MemWriteData});
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (ReqReady !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", ReqReady);
    end
  endtask

  task automatic test_word();
    logic [15:0] rd, ma, er_m, ema; logic er, ee; int lat, nrd, nwr, el, enr, enw; bit st, io, to;
    ref_exec(1'b1, 1'b0, 1'b0, 16'd2, 16'h1234, er_m, ee, el, enr, enw, ema);
    do_req(1'b1, 1'b0, 1'b0, 16'd2, 16'h1234, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || lat != 2 || er !== 1'b0 || nwr != 1 || ma !== 16'd2) begin
      failures++; $display("FAIL word_store got=lat%0d err%b nwr%0d addr%h tmo%b exp=lat2 err0 nwr1 addr0002", lat, er, nwr, ma, to);
    end
    checks++;
    if (mem[2] !== 8'h12 || mem[3] !== 8'h34) begin
      failures++; $display("FAIL word_store_bytes got=%h%h exp=1234", mem[2], mem[3]);
    end
    ref_exec(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, er_m, ee, el, enr, enw, ema);
    do_req(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || rd !== 16'h1234 || er !== 1'b0 || lat != 2 || !io) begin
      failures++; $display("FAIL word_load got=%h err%b lat%0d idle%b exp=1234 err0 lat2 idle1", rd, er, lat, io);
    end
  endtask

  task automatic test_byte();
    logic [15:0] rd, ma, er_m, ema; logic er, ee; int lat, nrd, nwr, el, enr, enw; bit st, io, to;
    logic [7:0] b4;
    b4 = ref_mem[4];
    ref_exec(1'b1, 1'b1, 1'b0, 16'd3, 16'h00AB, er_m, ee, el, enr, enw, ema);
    do_req(1'b1, 1'b1, 1'b0, 16'd3, 16'h00AB, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || lat != el || er !== ee || nrd != enr || nwr != enw) begin
      failures++; $display("FAIL byte_store got=lat%0d err%b rd%0d wr%0d exp=lat%0d err%b rd%0d wr%0d", lat, er, nrd, nwr, el, ee, enr, enw);
    end
    ref_exec(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, er_m, ee, el, enr, enw, ema);
    do_req(1'b0, 1'b0, 1'b0, 16'd2, 16'h0, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || rd !== er_m || rd !== (BYTE_EN ? 16'h12AB : 16'h1234)) begin
      failures++; $display("FAIL byte_store_readback got=%h exp=%h", rd, er_m);
    end
    checks++;
    if (mem[4] !== b4) begin
      failures++; $display("FAIL byte_store_neighbor got=%h exp=%h", mem[4], b4);
    end
    for (int s = 1; s >= 0; s--) begin
      ref_exec(1'b0, 1'b1, s[0], 16'd3, 16'h0, er_m, ee, el, enr, enw, ema);
      do_req(1'b0, 1'b1, s[0], 16'd3, 16'h0, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
      checks++;
      if (to || rd !== er_m || er !== ee || lat != el) begin
        failures++; $display("FAIL byte_load_signed%0d got=%h err%b lat%0d exp=%h err%b lat%0d", s, rd, er, lat, er_m, ee, el);
      end
    end
  endtask

  task automatic test_boundary();
    logic [15:0] rd, ma, er_m, ema; logic er, ee; int lat, nrd, nwr, el, enr, enw; bit st, io, to;
    logic [7:0] b126;
    b126 = ref_mem[126];
    ref_exec(1'b1, 1'b1, 1'b0, 16'd127, 16'h005A, er_m, ee, el, enr, enw, ema);
    do_req(1'b1, 1'b1, 1'b0, 16'd127, 16'h005A, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || ma !== ema || er !== ee || lat != el) begin
      failures++; $display("FAIL byte_store_127 got=addr%h err%b lat%0d exp=addr%h err%b lat%0d", ma, er, lat, ema, ee, el);
    end
    checks++;
    if (mem[126] !== b126 || mem[127] !== ref_mem[127]) begin
      failures++; $display("FAIL byte_store_127_bytes got=%h%h exp=%h%h", mem[126], mem[127], b126, ref_mem[127]);
    end
    ref_exec(1'b0, 1'b0, 1'b0, 16'd127, 16'h0, er_m, ee, el, enr, enw, ema);
    do_req(1'b0, 1'b0, 1'b0, 16'd127, 16'h0, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 16'h0 || lat != 1 || nrd != 0 || nwr != 0) begin
      failures++; $display("FAIL word_load_127 got=err%b data%h lat%0d rd%0d wr%0d exp=err1 data0000 lat1 rd0 wr0", er, rd, lat, nrd, nwr);
    end
    ref_exec(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, er_m, ee, el, enr, enw, ema);
    do_req(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || er !== 1'b1 || nwr != 0 || lat != 1) begin
      failures++; $display("FAIL word_store_ffff got=err%b wr%0d lat%0d exp=err1 wr0 lat1", er, nwr, lat);
    end
    ref_exec(1'b0, 1'b0, 1'b0, 16'd126, 16'h0, er_m, ee, el, enr, enw, ema);
    do_req(1'b0, 1'b0, 1'b0, 16'd126, 16'h0, 0, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || er !== 1'b0 || rd !== er_m) begin
      failures++; $display("FAIL word_load_126 got=%h err%b exp=%h err0", rd, er, er_m);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] rd, ma, er_m, ema; logic er, ee; int lat, nrd, nwr, el, enr, enw; bit st, io, to;
    logic [15:0] a;
    a = 16'($urandom_range(0, 126));
    ref_exec(1'b0, 1'b0, 1'b0, a, 16'h0, er_m, ee, el, enr, enw, ema);
    do_req(1'b0, 1'b0, 1'b0, a, 16'h0, 5, rd, er, lat, nrd, nwr, ma, st, io, to);
    checks++;
    if (to || !st || rd !== er_m) begin
      failures++; $display("FAIL backpressure_hold got=stable%b data%h exp=stable1 data%h", st, rd, er_m);
    end
    checks++;
    if (!io) begin
      failures++; $display("FAIL backpressure_release got=idle%b exp=idle1", io);
    end
  endtask

  task automatic test_reset_in_wr();
    int w;
    bit mismatch;
    ReqWrite = 1'b1; ReqByte = BYTE_EN; ReqSigned = 1'b0;
    ReqAddr = BYTE_EN ? 16'd3 : 16'd10; ReqWData = 16'hC3C3;
    ReqValid = 1'b1; RespReady = 1'b1;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    w = 0;
    while (MemWrite !== 1'b1 && w < 10) begin @(posedge Clock); #1; w++; end
    checks++;
    if (w >= 10) begin
      failures++; $display("FAIL reset_wr_reach got=no_write exp=write_cycle");
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      failures++; $display("FAIL reset_wr_gate got=%b exp=0", MemWrite);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      failures++; $display("FAIL reset_wr_idle got=ready%b valid%b exp=ready1 valid0", ReqReady, RespValid);
    end
    mismatch = 1'b0;
    repeat (3) begin
      @(posedge Clock); #1;
      if (RespValid !== 1'b0 || MemWrite !== 1'b0) mismatch = 1'b1;
    end
    for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) mismatch = 1'b1;
    checks++;
    if (mismatch) begin
      failures++; $display("FAIL reset_wr_quiet got=activity_or_mem_change exp=none");
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, ma, er_m, ema, a, wd; logic er, ee; int lat, nrd, nwr, el, enr, enw; bit st, io, to;
    bit wr, by, sg;
    int bad;
    for (int n = 0; n < 40; n++) begin
      wr = $urandom_range(0, 1) == 1; by = $urandom_range(0, 1) == 1; sg = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 140)) : 16'($urandom_range(118, 129));
      if (n % 13 == 12) a = 16'hFF00 | 16'($urandom_range(0, 255));
      wd = 16'($urandom);
      ref_exec(wr, by, sg, a, wd, er_m, ee, el, enr, enw, ema);
      do_req(wr, by, sg, a, wd, $urandom_range(0, 2), rd, er, lat, nrd, nwr, ma, st, io, to);
      checks++;
      if (to || rd !== er_m || er !== ee) begin
        failures++; $display("FAIL rand%0d_resp a=%h w%b b%b s%b got=%h err%b tmo%b exp=%h err%b", n, a, wr, by, sg, rd, er, to, er_m, ee);
      end
      checks++;
      if (lat != el || nrd != enr || nwr != enw || ((nrd + nwr) > 0 && ma !== ema)) begin
        failures++; $display("FAIL rand%0d_timing a=%h got=lat%0d rd%0d wr%0d addr%h exp=lat%0d rd%0d wr%0d addr%h", n, a, lat, nrd, nwr, ma, el, enr, enw, ema);
      end
      checks++;
      if (!st || !io) begin
        failures++; $display("FAIL rand%0d_handshake got=stable%b idle%b exp=stable1 idle1", n, st, io);
      end
      bad = 0;
      for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL rand%0d_mem got=%0d_bytes_differ exp=0", n, bad);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < MB; i++) begin
      b = 8'($urandom);
      mem[i] <= b;
      ref_mem[i] = b;
    end
    test_reset();
    test_word();
    test_byte();
    test_boundary();
    test_backpressure();
    test_reset_in_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
